// File: rtl/adder_accumulator_if.sv
//------------------------------------------------------------------------------
// Module      : adder_accumulator_if
// Description : Input and output stream handshakes of the adder accumulator.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface adder_accumulator_if #(
  parameter int N       = 32,
  parameter int COUNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       out_sum;
  logic               out_carry;
  logic               out_overflow;
  logic [COUNT_W-1:0] out_count;

  // master: the stream source and result sink; slave: the accumulator itself
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_overflow, out_count
  );
endinterface

`default_nettype wire

// File: rtl/adder_accumulator.sv
//------------------------------------------------------------------------------
// Module      : adder_accumulator
// Description : Streaming signed accumulator with sticky carry/overflow and a
//               saturating beat count, reported once per packet.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_accumulator #(
  parameter int N       = 32,
  parameter int COUNT_W = 8
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  clear,
  adder_accumulator_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  localparam logic c_cin = 1'b0;

  state_t             r_state;
  logic [N-1:0]       r_acc;
  logic               r_carry;
  logic               r_ovf;
  logic [COUNT_W-1:0] r_count;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [N:0]         w_add;
  logic               w_ovf;

  // Adder instance: X = acc, Y = in_data, Cin held at 0
  assign w_add = {1'b0, r_acc} + {1'b0, bus.in_data} + {{N{1'b0}}, c_cin};
  assign w_ovf = (r_acc[N-1] == bus.in_data[N-1]) && (w_add[N-1] != r_acc[N-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            r_acc   <= w_add[N-1:0];
            r_carry <= r_carry | w_add[N];
            r_ovf   <= r_ovf | w_ovf;
            if (!(&r_count)) begin
              r_count <= r_count + 1'b1;
            end
            if (bus.in_last) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Result is consumed; the next packet starts from a clean slate
          if (bus.out_ready) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_sum      = r_acc;
  assign bus.out_carry    = r_carry;
  assign bus.out_overflow = r_ovf;
  assign bus.out_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_adder_accumulator.sv
//------------------------------------------------------------------------------
// Module      : tb_adder_accumulator
// Description : Directed bench driving three accumulator widths in lockstep.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adder_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [31:0] in_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  adder_accumulator_if #(.N(32), .COUNT_W(8)) bus_a ();
  adder_accumulator_if #(.N(8),  .COUNT_W(2)) bus_b ();
  adder_accumulator_if #(.N(4),  .COUNT_W(8)) bus_c ();

  // Every instance sees the same handshakes; data is truncated to its width
  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_last   = in_last;
  assign bus_a.out_ready = out_ready;
  assign bus_a.in_data   = in_data;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_last   = in_last;
  assign bus_b.out_ready = out_ready;
  assign bus_b.in_data   = in_data[7:0];
  assign bus_c.in_valid  = in_valid;
  assign bus_c.in_last   = in_last;
  assign bus_c.out_ready = out_ready;
  assign bus_c.in_data   = in_data[3:0];

  adder_accumulator #(.N(32), .COUNT_W(8)) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(bus_a));
  adder_accumulator #(.N(8),  .COUNT_W(2)) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(bus_b));
  adder_accumulator #(.N(4),  .COUNT_W(8)) dut_c (.clk(clk), .rst(rst), .clear(clear), .bus(bus_c));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_sum",   64'(bus_a.out_sum), 64'd0);
    check("rst_count", 64'(bus_a.out_count), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 5 + 7 + 10
    beat(32'd5, 1'b0);
    beat(32'd7, 1'b0);
    check("p1_valid_early", 64'(bus_a.out_valid), 64'd0);
    beat(32'd10, 1'b1);
    check("p1_valid", 64'(bus_a.out_valid), 64'd1);
    check("p1_ready", 64'(bus_a.in_ready), 64'd0);
    check("p1_sum",   64'(bus_a.out_sum), 64'd22);
    check("p1_carry", 64'(bus_a.out_carry), 64'd0);
    check("p1_ovf",   64'(bus_a.out_overflow), 64'd0);
    check("p1_count", 64'(bus_a.out_count), 64'd3);
    check("p1_c_sum", 64'(bus_c.out_sum), 64'h6);
    check("p1_c_carry", 64'(bus_c.out_carry), 64'd1);
    check("p1_c_ovf", 64'(bus_c.out_overflow), 64'd1);
    handoff();
    check("p1_after_valid", 64'(bus_a.out_valid), 64'd0);
    check("p1_after_ready", 64'(bus_a.in_ready), 64'd1);
    check("p1_after_sum",   64'(bus_a.out_sum), 64'd0);

    // 7 + 1: positive overflow at 4 bits
    beat(32'd7, 1'b0);
    beat(32'd1, 1'b1);
    check("p2_c_sum",   64'(bus_c.out_sum), 64'h8);
    check("p2_c_ovf",   64'(bus_c.out_overflow), 64'd1);
    check("p2_c_carry", 64'(bus_c.out_carry), 64'd0);
    check("p2_a_ovf",   64'(bus_a.out_overflow), 64'd0);
    check("p2_a_count", 64'(bus_a.out_count), 64'd2);
    handoff();

    // -8 + -1: negative overflow at 4 bits, plain carry at wider widths
    beat(32'hFFFF_FFF8, 1'b0);
    beat(32'hFFFF_FFFF, 1'b1);
    check("p3_c_sum",   64'(bus_c.out_sum), 64'h7);
    check("p3_c_ovf",   64'(bus_c.out_overflow), 64'd1);
    check("p3_c_carry", 64'(bus_c.out_carry), 64'd1);
    check("p3_a_sum",   64'(bus_a.out_sum), 64'hFFFF_FFF7);
    check("p3_a_carry", 64'(bus_a.out_carry), 64'd1);
    check("p3_a_ovf",   64'(bus_a.out_overflow), 64'd0);
    check("p3_b_sum",   64'(bus_b.out_sum), 64'hF7);
    handoff();

    // 0xFF + 1: unsigned wrap at 8 bits, then a 5-cycle downstream stall
    beat(32'h0000_00FF, 1'b0);
    beat(32'h0000_0001, 1'b1);
    check("p4_b_sum",   64'(bus_b.out_sum), 64'h00);
    check("p4_b_carry", 64'(bus_b.out_carry), 64'd1);
    check("p4_b_ovf",   64'(bus_b.out_overflow), 64'd0);
    check("p4_a_sum",   64'(bus_a.out_sum), 64'h100);
    in_valid = 1'b1;
    in_data  = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 64'(bus_a.out_valid), 64'd1);
      check("stall_ready", 64'(bus_a.in_ready), 64'd0);
      check("stall_sum",   64'(bus_a.out_sum), 64'h100);
      check("stall_count", 64'(bus_a.out_count), 64'd2);
    end
    handoff();
    in_valid = 1'b0;
    check("p4_after_sum",   64'(bus_a.out_sum), 64'd0);
    check("p4_after_count", 64'(bus_a.out_count), 64'd0);

    // Five beats of 1: 2-bit counter saturates
    for (int i = 0; i < 4; i++) beat(32'd1, 1'b0);
    beat(32'd1, 1'b1);
    check("p5_b_count", 64'(bus_b.out_count), 64'd3);
    check("p5_b_sum",   64'(bus_b.out_sum), 64'd5);
    check("p5_a_count", 64'(bus_a.out_count), 64'd5);
    handoff();

    // clear mid-packet drops the offered beat
    beat(32'd3, 1'b0);
    beat(32'd4, 1'b0);
    check("p6_partial", 64'(bus_a.out_sum), 64'd7);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_sum",   64'(bus_a.out_sum), 64'd0);
    check("clr_count", 64'(bus_a.out_count), 64'd0);
    check("clr_valid", 64'(bus_a.out_valid), 64'd0);
    beat(32'd1, 1'b0);
    beat(32'd2, 1'b0);
    check("p6_partial2", 64'(bus_a.out_sum), 64'd3);
    // Asynchronous reset takes effect between edges
    #2 rst = 1'b1;
    #1;
    check("arst_sum",   64'(bus_a.out_sum), 64'd0);
    check("arst_count", 64'(bus_a.out_count), 64'd0);
    check("arst_ready", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat(32'd9, 1'b1);
    check("p7_valid", 64'(bus_a.out_valid), 64'd1);
    check("p7_sum",   64'(bus_a.out_sum), 64'd9);
    check("p7_count", 64'(bus_a.out_count), 64'd1);
    handoff();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
